// File: rtl/axis_if.sv
// AXI-stream bundle (tdata/tvalid/tready/tlast), parameterised on data width.
// Combinational wiring only; no latency.
// tready flows from the sink to the source.
interface axis_if #(
    parameter int QW = 64
);
    logic [QW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_chk.sv
// AXI-stream sink: checks N-beat framing, folds tdata into a MISR, keeps sticky status.
// Latency: sig/sig_valid/pkt_cnt update the cycle after the closing handshake.
// Backpressure: tready is registered, either held high or driven by a 75%-duty LFSR.
module axis_chk #(
    parameter int          N       = 16,
    parameter int          QW      = 64,
    parameter logic [63:0] POLY    = 64'h000000000000001B,
    parameter int          MODE    = 0,
    parameter logic [15:0] RSEED   = 16'hACE1,
    parameter int          TIMEOUT = 1024,
    parameter int          CNTW    = 32
) (
    input  logic            clk,
    input  logic            arstn,
    axis_if.slave           s,
    output logic [QW-1:0]   sig,
    output logic            sig_valid,
    output logic [CNTW-1:0] pkt_cnt,
    output logic            short_err,
    output logic            long_err,
    output logic            stall_err,
    output logic            busy
);
    localparam int BW = $clog2(N + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [QW-1:0] POLY_Q = POLY[QW-1:0];

    typedef enum logic [1:0] {IDLE, RX, DISCARD} state_t;

    state_t          state, state_nx;
    logic [BW-1:0]   beat, beat_nx;
    logic [QW-1:0]   acc, acc_nx, acc_upd, acc_sh;
    logic [WW-1:0]   wdog, wdog_nx;
    logic [15:0]     lfsr;
    logic            lfsr_fb;
    logic            hs, close, pkt_end, set_short, set_long;

    assign hs      = s.tvalid & s.tready;
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        state_nx  = state;
        beat_nx   = beat;
        acc_upd   = acc;
        close     = 1'b0;
        pkt_end   = 1'b0;
        set_short = 1'b0;
        set_long  = 1'b0;
        acc_sh    = {acc[QW-2:0], 1'b0} ^ (acc[QW-1] ? POLY_Q : '0);

        if (hs) begin
            unique case (state)
                IDLE: begin
                    acc_upd = s.tdata;
                    beat_nx = BW'(1);
                    if (s.tlast) begin
                        // a one-beat packet is still a closed (short) packet
                        close     = 1'b1;
                        set_short = 1'b1;
                    end else begin
                        state_nx = RX;
                    end
                end
                RX: begin
                    acc_upd = acc_sh ^ s.tdata;
                    if (s.tlast) begin
                        close     = 1'b1;
                        set_short = (beat != BW'(N - 1));
                        state_nx  = IDLE;
                    end else if (beat == BW'(N - 1)) begin
                        set_long = 1'b1;
                        state_nx = DISCARD;
                    end else begin
                        beat_nx = beat + 1'b1;
                    end
                end
                DISCARD: begin
                    if (s.tlast) begin
                        pkt_end  = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        acc_nx = acc_upd;
        if (close || pkt_end) begin
            beat_nx = '0;
            acc_nx  = '0;
        end

        // watchdog only runs while a packet is open, saturating at TIMEOUT
        wdog_nx = wdog;
        if (state == IDLE || hs) begin
            wdog_nx = '0;
        end else if (wdog != WW'(TIMEOUT)) begin
            wdog_nx = wdog + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= IDLE;
            beat      <= '0;
            acc       <= '0;
            sig       <= '0;
            sig_valid <= 1'b0;
            pkt_cnt   <= '0;
            short_err <= 1'b0;
            long_err  <= 1'b0;
            stall_err <= 1'b0;
            busy      <= 1'b0;
            s.tready  <= 1'b0;
            lfsr      <= RSEED;
            wdog      <= '0;
        end else begin
            state     <= state_nx;
            beat      <= beat_nx;
            acc       <= acc_nx;
            wdog      <= wdog_nx;
            lfsr      <= {lfsr[14:0], lfsr_fb};
            sig_valid <= close;
            busy      <= (state_nx != IDLE);
            s.tready  <= (MODE == 0) ? 1'b1 : (lfsr[0] | lfsr[1]);
            if (close) begin
                sig     <= acc_upd;
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (set_short)
                short_err <= 1'b1;
            if (set_long)
                long_err <= 1'b1;
            if (state != IDLE && wdog_nx == WW'(TIMEOUT))
                stall_err <= 1'b1;
        end
    end
endmodule
